// File: rtl/fight_pkg.sv
// Shared encodings for the two-player fight core: action codes, one-hot positions, health limit.
package fight_pkg;

  localparam logic [2:0] ACT_KICK   = 3'b000;
  localparam logic [2:0] ACT_PUNCH  = 3'b001;
  localparam logic [2:0] ACT_AWAIT  = 3'b010;
  localparam logic [2:0] ACT_JUMP   = 3'b011;
  localparam logic [2:0] ACT_LEFT1  = 3'b100;
  localparam logic [2:0] ACT_LEFT2  = 3'b101;
  localparam logic [2:0] ACT_RIGHT1 = 3'b110;
  localparam logic [2:0] ACT_RIGHT2 = 3'b111;

  // Player 1 is mirrored: its S0 sits at the far left bit.
  localparam logic [2:0] P1_S0 = 3'b100;
  localparam logic [2:0] P1_S1 = 3'b010;
  localparam logic [2:0] P1_S2 = 3'b001;

  localparam logic [2:0] P2_S0 = 3'b001;
  localparam logic [2:0] P2_S1 = 3'b010;
  localparam logic [2:0] P2_S2 = 3'b100;

  localparam logic [1:0] HEALTH_MAX = 2'd3;

  typedef enum logic [2:0] {
    St0 = P2_S0,
    St1 = P2_S1,
    St2 = P2_S2
  } p2_state_e;

  function automatic p2_state_e p2_advance(input p2_state_e s);
    case (s)
      St0:     return St1;
      default: return St2;
    endcase
  endfunction

  function automatic p2_state_e p2_retreat(input p2_state_e s);
    case (s)
      St2:     return St1;
      default: return St0;
    endcase
  endfunction

endpackage

// File: rtl/second_player_if.sv
// Player-2 action/state bus: game side drives actions and strobes, player side publishes state.
interface second_player_if;
  logic       action_enable;
  logic       is_game_over;
  logic [2:0] action1;
  logic [2:0] action2;
  logic [2:0] state1;
  logic [2:0] state2;
  logic [1:0] health2;
  logic       hit_taken;
  logic       ko;

  modport master (
    output action_enable, is_game_over, action1, action2, state1,
    input  state2, health2, hit_taken, ko
  );

  modport slave (
    input  action_enable, is_game_over, action1, action2, state1,
    output state2, health2, hit_taken, ko
  );
endinterface

// File: rtl/hit_resolver.sv
// Combinational player-1 attack resolution against player 2 on pre-step positions.
module hit_resolver
  import fight_pkg::*;
(
  input  logic [2:0] action1,
  input  logic [2:0] action2,
  input  logic [2:0] state1,
  input  logic [2:0] state2,
  output logic [1:0] dmg,
  output logic       knockback
);

  logic [1:0] i1, i2;
  logic       v1, v2;
  logic [2:0] sum;

  always_comb begin
    v1 = 1'b1;
    i1 = 2'd0;
    case (state1)
      P1_S0:   i1 = 2'd0;
      P1_S1:   i1 = 2'd1;
      P1_S2:   i1 = 2'd2;
      default: v1 = 1'b0;
    endcase

    v2 = 1'b1;
    i2 = 2'd0;
    case (state2)
      P2_S0:   i2 = 2'd0;
      P2_S1:   i2 = 2'd1;
      P2_S2:   i2 = 2'd2;
      default: v2 = 1'b0;
    endcase

    sum       = {1'b0, i1} + {1'b0, i2};
    dmg       = 2'd0;
    knockback = 1'b0;
    // A garbled position on either side means nothing lands this step.
    if (v1 && v2) begin
      if (action1 == ACT_KICK && sum >= 3'd3 && action2 != ACT_JUMP) begin
        dmg       = 2'd1;
        knockback = (i2 == 2'd2);
      end else if (action1 == ACT_PUNCH && sum == 3'd4 && action2 != ACT_PUNCH) begin
        dmg = 2'd2;
      end
    end
  end

endmodule

// File: rtl/second_player.sv
// Player-2 position FSM, health, heal and ko tracking, one step per action strobe.
// Optional hit immunity window enabled by defining SECOND_PLAYER_INVULN_EN.
module second_player
  import fight_pkg::*;
#(
  parameter int unsigned WAIT_HEAL    = 2,
  parameter int unsigned INVULN_STEPS = 2
) (
  input logic            clk,
  input logic            rst_n,
  second_player_if.slave bus
);

  if (WAIT_HEAL < 1 || WAIT_HEAL > 3) begin : g_bad_wait_heal
    $error("WAIT_HEAL must be in 1..3");
  end
  if (INVULN_STEPS > 7) begin : g_bad_invuln_steps
    $error("INVULN_STEPS must fit the 3-bit immunity counter");
  end

  p2_state_e  state_q, state_d;
  logic [1:0] health_q, health_d;
  logic [1:0] wait_q, wait_d;
  logic       hit_q, hit_d;
  logic       ko_q, ko_d;
  logic [1:0] dmg_raw, dmg;
  logic       knockback;
  logic       step;

  hit_resolver u_hit_resolver (
    .action1   (bus.action1),
    .action2   (bus.action2),
    .state1    (bus.state1),
    .state2    (state_q),
    .dmg       (dmg_raw),
    .knockback (knockback)
  );

  assign step = bus.action_enable && !bus.is_game_over && !ko_q;

`ifdef SECOND_PLAYER_INVULN_EN
  logic [2:0] inv_q, inv_d;

  assign dmg = (inv_q != 3'd0) ? 2'd0 : dmg_raw;

  always_comb begin
    inv_d = inv_q;
    if (step) begin
      if (dmg != 2'd0) begin
        inv_d = 3'(INVULN_STEPS);
      end else if (inv_q != 3'd0) begin
        inv_d = inv_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 3'd0;
    end else begin
      inv_q <= inv_d;
    end
  end
`else
  assign dmg = dmg_raw;
`endif

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    wait_d   = wait_q;
    ko_d     = ko_q;
    hit_d    = 1'b0;

    if (step) begin
      if (!$onehot(state_q)) begin
        state_d = St0;
      end else if (knockback) begin
        state_d = St1;
      end else begin
        case (bus.action2)
          ACT_LEFT1, ACT_LEFT2:   state_d = p2_advance(state_q);
          ACT_RIGHT1, ACT_RIGHT2: state_d = p2_retreat(state_q);
          default:                ;
        endcase
      end

      if (dmg != 2'd0) begin
        hit_d    = 1'b1;
        wait_d   = 2'd0;
        health_d = (health_q > dmg) ? health_q - dmg : 2'd0;
        ko_d     = ko_q | (health_q <= dmg);
      end else if (bus.action2 == ACT_AWAIT) begin
        if (32'(wait_q) + 32'd1 == WAIT_HEAL) begin
          wait_d   = 2'd0;
          health_d = (health_q == HEALTH_MAX) ? HEALTH_MAX : health_q + 2'd1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end else begin
        wait_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= St0;
      health_q <= HEALTH_MAX;
      wait_q   <= 2'd0;
      hit_q    <= 1'b0;
      ko_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      wait_q   <= wait_d;
      hit_q    <= hit_d;
      ko_q     <= ko_d;
    end
  end

  assign bus.state2    = state_q;
  assign bus.health2   = health_q;
  assign bus.hit_taken = hit_q;
  assign bus.ko        = ko_q;

endmodule

// File: tb/tb_second_player.sv
// Bench for second_player: directed vector table, hand sequences, and a random run against
// an index-based reference model.
module tb_second_player;
  import fight_pkg::*;

  localparam int WAIT_HEAL_TB = 2;
  localparam int INVULN_TB    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  second_player_if bus ();

  second_player #(
    .WAIT_HEAL    (WAIT_HEAL_TB),
    .INVULN_STEPS (INVULN_TB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: position index, health, counters.
  int m_pos, m_health, m_wait, m_inv;
  bit m_ko, m_hit;

  typedef struct {
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] s1;
    logic [2:0] st;
    logic [1:0] h;
    logic       hit;
    logic       ko;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] s1,
                             input logic [2:0] st, input logic [1:0] h, input logic hit,
                             input logic ko);
    vec_t r;
    r.a1 = a1; r.a2 = a2; r.s1 = s1; r.st = st; r.h = h; r.hit = hit; r.ko = ko;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int p1_idx(input logic [2:0] s);
    if (s == 3'b100) return 0;
    if (s == 3'b010) return 1;
    if (s == 3'b001) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_health = 3; m_wait = 0; m_inv = 0; m_ko = 0; m_hit = 0;
  endtask

  task automatic model_step(input bit en, input bit go, input logic [2:0] a1,
                            input logic [2:0] a2, input logic [2:0] s1);
    int i1, dmg;
    bit kb;
    m_hit = 0;
    if (!en || go || m_ko) return;
    i1  = p1_idx(s1);
    dmg = 0;
    kb  = 0;
    if (i1 >= 0) begin
      if (a1 == 3'd0 && i1 + m_pos >= 3 && a2 != 3'd3) begin
        dmg = 1;
        kb  = (m_pos == 2);
      end else if (a1 == 3'd1 && i1 + m_pos == 4 && a2 != 3'd1) begin
        dmg = 2;
      end
    end
`ifdef SECOND_PLAYER_INVULN_EN
    if (m_inv > 0) begin
      dmg = 0;
      m_inv--;
    end
    if (dmg > 0) m_inv = INVULN_TB;
`endif
    if (kb) m_pos = 1;
    else if (a2 == 3'd4 || a2 == 3'd5) m_pos = (m_pos < 2) ? m_pos + 1 : 2;
    else if (a2 == 3'd6 || a2 == 3'd7) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
    if (dmg > 0) begin
      m_hit    = 1;
      m_wait   = 0;
      m_health = m_health - dmg;
      if (m_health <= 0) begin
        m_health = 0;
        m_ko     = 1;
      end
    end else if (a2 == 3'd2) begin
      m_wait++;
      if (m_wait == WAIT_HEAL_TB) begin
        m_wait   = 0;
        m_health = (m_health < 3) ? m_health + 1 : 3;
      end
    end else begin
      m_wait = 0;
    end
  endtask

  // Called at a negedge: drive, let one posedge pass, then compare against the model.
  task automatic apply(input bit en, input bit go, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] s1, input string tag);
    logic [2:0] exp_st;
    bus.action_enable = en;
    bus.is_game_over  = go;
    bus.action1       = a1;
    bus.action2       = a2;
    bus.state1        = s1;
    @(negedge clk);
    model_step(en, go, a1, a2, s1);
    exp_st = 3'b001 << m_pos;
    chk({tag, " state2"}, int'(bus.state2), int'(exp_st));
    chk({tag, " health2"}, int'(bus.health2), m_health);
    chk({tag, " hit_taken"}, int'(bus.hit_taken), int'(m_hit));
    chk({tag, " ko"}, int'(bus.ko), int'(m_ko));
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.action_enable = 1'b0;
    bus.is_game_over  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " state2"}, int'(bus.state2), 1);
    chk({tag, " health2"}, int'(bus.health2), 3);
    chk({tag, " hit_taken"}, int'(bus.hit_taken), 0);
    chk({tag, " ko"}, int'(bus.ko), 0);
  endtask

  initial begin
    bus.action1 = ACT_AWAIT;
    bus.action2 = ACT_AWAIT;
    bus.state1  = P1_S0;

    // Directed sequence from reset; expected values worked out by hand.
    tbl.push_back(v(ACT_AWAIT, ACT_LEFT1, 3'b100, 3'b010, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_LEFT1, 3'b100, 3'b100, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_LEFT1, 3'b100, 3'b100, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_KICK,  ACT_JUMP,  3'b001, 3'b100, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_KICK,  ACT_AWAIT, 3'b001, 3'b010, 2'd2, 1'b1, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_LEFT1, 3'b001, 3'b100, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(ACT_PUNCH, ACT_KICK,  3'b001, 3'b100, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b100, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_KICK,  ACT_AWAIT, 3'b001, 3'b010, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_AWAIT, 3'b001, 3'b010, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_AWAIT, ACT_LEFT1, 3'b001, 3'b100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_PUNCH, ACT_AWAIT, 3'b011, 3'b100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_PUNCH, ACT_PUNCH, 3'b001, 3'b100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(ACT_PUNCH, ACT_JUMP,  3'b001, 3'b100, 2'd0, 1'b1, 1'b1));
    tbl.push_back(v(ACT_KICK,  ACT_LEFT1, 3'b001, 3'b100, 2'd0, 1'b0, 1'b1));

    do_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("reset idle");

    for (int i = 0; i < tbl.size(); i++) begin
      bus.action_enable = 1'b1;
      bus.is_game_over  = 1'b0;
      bus.action1       = tbl[i].a1;
      bus.action2       = tbl[i].a2;
      bus.state1        = tbl[i].s1;
      @(negedge clk);
      chk($sformatf("vec%0d state2", i), int'(bus.state2), int'(tbl[i].st));
      chk($sformatf("vec%0d health2", i), int'(bus.health2), int'(tbl[i].h));
      chk($sformatf("vec%0d hit_taken", i), int'(bus.hit_taken), int'(tbl[i].hit));
      chk($sformatf("vec%0d ko", i), int'(bus.ko), int'(tbl[i].ko));
    end
    bus.action_enable = 1'b0;

    // Reset from a ko'd, mid-game state.
    do_reset();
    @(negedge clk);
    chk_reset_state("mid reset");

    // Strobes held while reset is asserted must not move player 2.
    rst_n             = 1'b0;
    bus.action_enable = 1'b1;
    bus.action2       = ACT_LEFT2;
    repeat (2) @(negedge clk);
    rst_n             = 1'b1;
    bus.action_enable = 1'b0;
    @(negedge clk);
    chk_reset_state("strobe in reset");
    model_reset();

    // hit_taken is a single-cycle pulse; game over freezes everything.
    apply(1, 0, ACT_AWAIT, ACT_LEFT1, P1_S2, "adv1");
    apply(1, 0, ACT_AWAIT, ACT_LEFT2, P1_S2, "adv2");
    apply(1, 0, ACT_KICK, ACT_AWAIT, P1_S2, "kick hit");
    apply(0, 0, ACT_AWAIT, ACT_AWAIT, P1_S2, "after hit");
    chk("hit pulse drop", int'(bus.hit_taken), 0);
    apply(1, 1, ACT_PUNCH, ACT_RIGHT1, P1_S2, "game over");
    chk("game over hold", int'(bus.state2), 2);

`ifdef SECOND_PLAYER_INVULN_EN
    do_reset();
    apply(1, 0, ACT_AWAIT, ACT_LEFT1, P1_S2, "inv adv1");
    apply(1, 0, ACT_AWAIT, ACT_LEFT1, P1_S2, "inv adv2");
    apply(1, 0, ACT_KICK, ACT_AWAIT, P1_S2, "inv k1");
    chk("inv k1 health", int'(bus.health2), 2);
    apply(1, 0, ACT_KICK, ACT_LEFT1, P1_S2, "inv k2");
    chk("inv k2 health", int'(bus.health2), 2);
    apply(1, 0, ACT_KICK, ACT_AWAIT, P1_S2, "inv k3");
    chk("inv k3 knockback", int'(bus.state2), 2);
    chk("inv k3 health", int'(bus.health2), 2);
    apply(1, 0, ACT_KICK, ACT_AWAIT, P1_S2, "inv k4");
    chk("inv k4 health", int'(bus.health2), 1);
`endif

    // Random run; attacks and one-hot P1 positions are favoured so hits actually land.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit         en, go;
      logic [2:0] a1, a2, s1;
      en = ($urandom_range(0, 3) != 0);
      go = ($urandom_range(0, 15) == 0);
      a1 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 4) != 0) ? 3'(3'b001 << $urandom_range(0, 2))
                                       : 3'($urandom_range(0, 7));
      apply(en, go, a1, a2, s1, $sformatf("rand%0d", n));
      if (m_ko && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
